red_pitaya_pwm_bank: RTL and testbench
======================================

// Module: red_pitaya_pwm_bank
// PURPOSE
//  Four-channel sigma-modulated PWM generator; the analog-output stage fed by the AMS register block.
//  Each channel consumes a 24-bit config word {duty[7:0], seq[15:0]} and drives one slow-DAC PWM pin.
//  Base PWM period is 256 clocks (488.28 kHz at 125 MHz); the 16-period superperiod adds 4-bit dither.
//  A config update takes effect only at a superperiod boundary, so no glitched periods are produced.
// PARAMETERS
//  CCW      24   config word width: [23:16] duty, [15:0] dither sequence
//  CNT_W    8    PWM counter width; period = 2**CNT_W clocks
//  SEQ_LEN  16   PWM periods per superperiod; equals the width of the seq field
//  NCH      4    number of channels
// PORTS
//  clk_i      in   1        single clock; all logic on its rising edge
//  rst_i      in   1        asynchronous, active-high reset
//  cfg_a_i    in   CCW      channel A config; sampled at the superperiod boundary
//  cfg_b_i    in   CCW      channel B config
//  cfg_c_i    in   CCW      channel C config
//  cfg_d_i    in   CCW      channel D config
//  pwm_o      out  NCH      registered PWM outputs; bit0 = A .. bit3 = D
//  sync_o     out  1        1-cycle pulse on the first clock of each superperiod
// BEHAVIOUR
//  - Reset (async, immediate): v_cnt=0, b_cnt=0, all shadow duty/seq=0, pwm_o=0, sync_o=0.
//  - v_cnt (CNT_W bits) increments every clock and wraps 255->0.
//  - b_cnt (4 bits) increments when v_cnt==255 and wraps 15->0.
//  - load = (v_cnt==255 && b_cnt==15). On load, all four shadows capture in the same cycle:
//    duty_x<=cfg_x_i[23:16] and seq_x<=cfg_x_i[15:0]. Inputs are ignored on all other cycles.
//  - When v_cnt==255 and not load: seq_x <= {seq_x[0], seq_x[15:1]} (rotate right).
//    As a result, PWM period k of a superperiod uses cfg bit k.
//  - Compare, registered with 1-cycle latency:
//    pwm_o[x] <= ({1'b0,v_cnt} < ({1'b0,duty_x} + seq_x[0]));
//    the 9-bit compare is mandatory.
//    duty=255 with bit=1 -> 256 -> output stays high for the whole period;
//    duty=0 with bit=0 -> output stays low.
//  - High clocks per superperiod = 16*duty + popcount(seq); the range is 0..4096.
//  - sync_o <= load; it is high during the cycle where v_cnt==0 and b_cnt==0, once per 4096 clocks.
//  - After reset the shadows are 0, so pwm_o stays low until the first load.
//    The first new pwm_o value appears at clock 4097 after reset release.
//  - A cfg change in the middle of a superperiod is not visible until the next load.
//    A change on the load cycle itself is captured.
//  - Reset asserted mid-period clears the outputs immediately.
//    Counting restarts from v_cnt=0 after release; no partial period is completed.
//  - No bus interface and no handshake: the upstream block holds cfg stable and this block samples it.
//  - The upstream encoder leaves seq[15]=0, but this block accepts any 16-bit pattern unchanged.
// STRUCTURE
//  - Shared package pwm_pkg: CCW, CNT_W, SEQ_LEN, NCH, and field slices DUTY_MSB/LSB=23/16, SEQ_MSB/LSB=15/0.
//  - Sub-module pwm_channel (one per channel, NCH instances):
//    inputs: cfg, load, period_end (v_cnt==255), v_cnt;
//    contents: shadow duty/seq, rotation, compare, and the pwm flop.
//  - Top level holds one shared timebase (v_cnt, b_cnt, load, sync_o); all channels are phase-aligned.
// TESTING
//  1. Reset, then cfg_a=0x800000 -> after the first load, pwm_o[0] is high for exactly 128 of every 256 clocks.
//     Its rising edge comes 1 clock after v_cnt==0.
//  2. cfg_b=0xFFFFFF -> pwm_o[1] stays constantly high.
//     cfg_c=0x000000 -> pwm_o[2] stays constantly low.
//     cfg_d=0xFF0000 -> pwm_o[3] is low exactly 1 clock per period.
//  3. cfg_a=0x100001 -> period 0 has 17 high clocks, periods 1..15 have 16.
//     Total is 257 per 4096 clocks; sync_o pulses every 4096 clocks.
//  4. cfg_a=0x405555 -> high counts alternate 65/64 per period.
//     cfg_a=0x400080 -> only period 7 has 65.
//  5. Change cfg_a from 0x200000 to 0xE00000 at b_cnt=5 -> duty 32 holds through period 15.
//     Duty 224 starts in the period right after sync_o.
//  6. Assert rst_i mid-period with pwm_o high -> pwm_o=0 and sync_o=0 in the same cycle.
//     After release, pwm_o stays low for 4096 clocks, then resumes the held cfg.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths, config-word field positions and the unpacked channel config
// for the four-channel sigma-modulated PWM bank.
package pwm_pkg;

    localparam int unsigned CCW      = 24;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SEQ_LEN  = 16;
    localparam int unsigned NCH      = 4;
    localparam int unsigned BCNT_W   = 4;

    localparam int unsigned DUTY_MSB = 23;
    localparam int unsigned DUTY_LSB = 16;
    localparam int unsigned SEQ_MSB  = 15;
    localparam int unsigned SEQ_LSB  = 0;

    localparam int unsigned DUTY_W   = DUTY_MSB - DUTY_LSB + 1;
    localparam int unsigned SEQ_W    = SEQ_MSB - SEQ_LSB + 1;

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic [SEQ_W-1:0]  seq;
    } pwm_cfg_t;

    // Split a raw config word into duty and dither fields.
    function automatic pwm_cfg_t unpack_cfg(input logic [CCW-1:0] word);
        pwm_cfg_t c;
        c.duty = word[DUTY_MSB:DUTY_LSB];
        c.seq  = word[SEQ_MSB:SEQ_LSB];
        return c;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed duty/dither registers, per-period dither rotation
// and the registered 9-bit compare that drives the output pin.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CCW-1:0]   cfg,
    input  logic             load,
    input  logic             period_end,
    input  logic [CNT_W-1:0] v_cnt,
    output logic             pwm
);

    pwm_cfg_t           cfg_c;
    logic [DUTY_W-1:0]  duty;
    logic [SEQ_W-1:0]   seq;
    logic [CNT_W:0]     thresh_c;
    logic [CNT_W:0]     v_ext_c;

    assign cfg_c = unpack_cfg(cfg);

    // Extra MSB lets duty=255 plus a dither bit reach 256, i.e. a full-high period.
    assign thresh_c = (CNT_W+1)'(duty) + (CNT_W+1)'(seq[0]);
    assign v_ext_c  = {1'b0, v_cnt};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            duty <= '0;
            seq  <= '0;
            pwm  <= 1'b0;
        end else begin
            if (load) begin
                duty <= cfg_c.duty;
                seq  <= cfg_c.seq;
            end else if (period_end) begin
                seq  <= {seq[0], seq[SEQ_W-1:1]};
            end
            pwm <= (v_ext_c < thresh_c);
        end
    end

endmodule

// File: rtl/red_pitaya_pwm_bank.sv
// Four-channel PWM bank with one shared timebase; config words are sampled
// only at the superperiod boundary so every channel stays phase-aligned.
module red_pitaya_pwm_bank
    import pwm_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [CCW-1:0] cfg_a_i,
    input  logic [CCW-1:0] cfg_b_i,
    input  logic [CCW-1:0] cfg_c_i,
    input  logic [CCW-1:0] cfg_d_i,
    output logic [NCH-1:0] pwm_o,
    output logic           sync_o
);

    logic [CNT_W-1:0]  v_cnt;
    logic [BCNT_W-1:0] b_cnt;
    logic              period_end_c;
    logic              load_c;
    logic [CCW-1:0]    cfg_arr [NCH];

    assign period_end_c = (v_cnt == '1);
    assign load_c       = period_end_c && (b_cnt == '1);

    assign cfg_arr[0] = cfg_a_i;
    assign cfg_arr[1] = cfg_b_i;
    assign cfg_arr[2] = cfg_c_i;
    assign cfg_arr[3] = cfg_d_i;

    // Shared timebase: 256-clock period counter and 16-period superperiod counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_cnt  <= '0;
            b_cnt  <= '0;
            sync_o <= 1'b0;
        end else begin
            v_cnt  <= v_cnt + CNT_W'(1);
            if (period_end_c) begin
                b_cnt <= b_cnt + BCNT_W'(1);
            end
            sync_o <= load_c;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .cfg        (cfg_arr[i]),
            .load       (load_c),
            .period_end (period_end_c),
            .v_cnt      (v_cnt),
            .pwm        (pwm_o[i])
        );
    end

endmodule

// File: tb/tb_red_pitaya_pwm_bank.sv
// Randomized self-checking bench for red_pitaya_pwm_bank against a
// clock-index arithmetic model of the superperiod PWM.
module tb_red_pitaya_pwm_bank;
    import pwm_pkg::*;

    localparam int unsigned SUPER = 4096;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [CCW-1:0] cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i;
    logic [NCH-1:0] pwm_o;
    logic           sync_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model state: edges since reset release and the config each channel is using.
    int unsigned    n = 0;
    logic [CCW-1:0] sh [NCH];
    logic [NCH-1:0] exp_pwm = '0;
    logic           exp_sync = 1'b0;
    int unsigned    win_exp [NCH];
    int unsigned    hc [NCH];

    red_pitaya_pwm_bank dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cfg_a_i (cfg_a_i),
        .cfg_b_i (cfg_b_i),
        .cfg_c_i (cfg_c_i),
        .cfg_d_i (cfg_d_i),
        .pwm_o   (pwm_o),
        .sync_o  (sync_o)
    );

    always #4 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [CCW-1:0] cfg_of(input int ch);
        case (ch)
            0:       return cfg_a_i;
            1:       return cfg_b_i;
            2:       return cfg_c_i;
            default: return cfg_d_i;
        endcase
    endfunction

    // Output after edge n reflects clock m=n-1: position m%256 in period (m/256)%16.
    always @(posedge clk_i) begin
        if (rst_i) begin
            n = 0;
            exp_pwm = '0;
            exp_sync = 1'b0;
            for (int ch = 0; ch < NCH; ch++) sh[ch] = '0;
        end else begin
            int unsigned m, v, k, thr;
            n++;
            m = n - 1;
            v = m % 256;
            k = (m / 256) % 16;
            for (int ch = 0; ch < NCH; ch++) begin
                thr = int'(sh[ch][23:16]) + int'(sh[ch][k]);
                exp_pwm[ch] = (v < thr);
            end
            exp_sync = (n % SUPER == 0);
            if (n % SUPER == 0) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    win_exp[ch] = 16 * int'(sh[ch][23:16]) + $countones(sh[ch][15:0]);
                    sh[ch] = cfg_of(ch);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NCH; ch++) hc[ch] = 0;
        end else if (n > 0) begin
            check("pwm", 32'(pwm_o), 32'(exp_pwm));
            check("sync", 32'(sync_o), 32'(exp_sync));
            for (int ch = 0; ch < NCH; ch++) hc[ch] += int'(pwm_o[ch]);
            if (n % SUPER == 0) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    check($sformatf("hcount_ch%0d", ch), hc[ch], win_exp[ch]);
                    hc[ch] = 0;
                end
            end
        end
    end

    task automatic run(input int unsigned cyc);
        repeat (cyc) @(negedge clk_i);
    endtask

    task automatic wait_phase(input int unsigned ph);
        int unsigned t = 0;
        while ((n % SUPER) != ph && t < 2 * SUPER) begin
            @(negedge clk_i);
            t++;
        end
        check("wait_phase", 32'(t < 2 * SUPER), 32'd1);
    endtask

    initial begin
        rst_i   = 1'b1;
        cfg_a_i = '0;
        cfg_b_i = '0;
        cfg_c_i = '0;
        cfg_d_i = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            win_exp[ch] = 0;
            hc[ch] = 0;
            sh[ch] = '0;
        end
        repeat (3) @(negedge clk_i);
        check("reset_pwm", 32'(pwm_o), 32'd0);
        check("reset_sync", 32'(sync_o), 32'd0);
        rst_i = 1'b0;

        // Half duty, full high, full low, one-low-clock-per-period.
        cfg_a_i = 24'h800000;
        cfg_b_i = 24'hFFFFFF;
        cfg_c_i = 24'h000000;
        cfg_d_i = 24'hFF0000;
        run(2 * SUPER + 10);

        cfg_a_i = 24'h100001;
        run(SUPER);
        cfg_a_i = 24'h405555;
        run(SUPER);
        cfg_a_i = 24'h400080;
        run(SUPER);

        // Mid-superperiod change must wait for the next boundary.
        cfg_a_i = 24'h200000;
        wait_phase(0);
        wait_phase(5 * 256 + 17);
        cfg_a_i = 24'hE00000;
        run(SUPER + 300);

        // A change driven during the load cycle itself is captured.
        wait_phase(SUPER - 1);
        cfg_c_i = 24'h3CA5F1;
        run(600);

        for (int i = 0; i < 24; i++) begin
            run($urandom_range(200, 1200));
            case ($urandom_range(0, 3))
                0:       cfg_a_i = 24'($urandom);
                1:       cfg_b_i = 24'($urandom);
                2:       cfg_c_i = 24'($urandom);
                default: cfg_d_i = 24'($urandom);
            endcase
        end

        // Reset while a channel output is high clears outputs immediately.
        cfg_b_i = 24'hFFFFFF;
        wait_phase(0);
        wait_phase(100);
        begin
            int unsigned t = 0;
            while (pwm_o[1] !== 1'b1 && t < 300) begin
                @(negedge clk_i);
                t++;
            end
            check("pwm_high_before_rst", 32'(pwm_o[1]), 32'd1);
        end
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_o), 32'd0);
        check("async_rst_sync", 32'(sync_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        run(SUPER + 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
